// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control FSM: state codes,
// opcodes, ALUOp and ALUSrcB encodings.
package riscv_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_RESET  = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_MEMADR = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_MEMWB  = 4'd5;
  localparam state_t S_MEMWR  = 4'd6;
  localparam state_t S_EXEC   = 4'd7;
  localparam state_t S_ALUWB  = 4'd8;
  localparam state_t S_BRANCH = 4'd9;
  localparam state_t S_TRAP   = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_wait(input state_t st);
    return (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Watchdog for memory waits: counts not-ready cycles in a waiting state and
// flags expiry on the last allowed cycle.
module ctrl_wait_timer #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  input  logic ready,
  input  logic state_change,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    expired = in_wait && !ready && (cnt_q == WAIT_W'(MAX_WAIT - 1));
    cnt_d   = cnt_q;
    // An abort from FETCH re-enters FETCH, so expiry must clear on its own.
    if (state_change || expired) begin
      cnt_d = '0;
    end else if (in_wait && !ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V datapath (ld, sd, beq, R-type).
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in S_TRAP.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSource,
  output logic [3:0] State,
  output logic       mem_timeout,
  output logic       illegal_instr
);

  state_t state_q;
  state_t state_d;
  logic   mem_timeout_q;
  logic   mem_timeout_d;
  logic   expired;
  logic   state_change;

  ctrl_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_wait      (is_mem_wait(state_q)),
    .ready        (mem_ready),
    .state_change (state_change),
    .expired      (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (expired) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else if (expired) state_d = S_FETCH;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready || expired) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase
    state_change  = (state_d != state_q);
    mem_timeout_d = mem_timeout_q | expired;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Moore decode except FETCH, where IR/PC loads wait for the read to land.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State       = state_q;
  assign mem_timeout = mem_timeout_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, random
// instruction stream against a trace-level model, and corner-case sequences.
module tb_multicycle_control;

  localparam int MAX_WAIT = 16;

  localparam logic [3:0] T_RESET = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2, T_MEMADR = 4'd3,
                         T_MEMRD = 4'd4, T_MEMWB = 4'd5, T_MEMWR = 4'd6, T_EXEC = 4'd7,
                         T_ALUWB = 4'd8, T_BRANCH = 4'd9, T_TRAP = 4'd10;

  localparam logic [6:0] LD = 7'b0000011, SD = 7'b0100011, ADD = 7'b0110011,
                         BEQ = 7'b1100011, BAD = 7'b1111111;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  localparam logic [13:0] C_FETCH_R = 14'h2508, C_FETCH_W = 14'h0408, C_DEC = 14'h0010,
                          C_MADR = 14'h0030, C_MRD = 14'h0C00, C_MWB = 14'h00C0,
                          C_MWR = 14'h0A00, C_EXEC = 14'h0024, C_ALUWB = 14'h0040,
                          C_BR = 14'h1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
  logic ALUSrcA, PCSource, mem_timeout, illegal_instr;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_control #(.MAX_WAIT(MAX_WAIT), .WAIT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .mem_timeout(mem_timeout), .illegal_instr(illegal_instr)
  );

  wire [13:0] ctrl_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                          MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic        to;
    logic        ill;
    string       tag;
  } vec_t;

  vec_t  dir_q[$];
  vec_t  exp_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  logic  to_m = 1'b0;
  string pending_tag = "";

  function automatic void check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [13:0] ctrl_of(logic [3:0] st, logic rdy);
    case (st)
      T_FETCH:  return rdy ? C_FETCH_R : C_FETCH_W;
      T_DECODE: return C_DEC;
      T_MEMADR: return C_MADR;
      T_MEMRD:  return C_MRD;
      T_MEMWB:  return C_MWB;
      T_MEMWR:  return C_MWR;
      T_EXEC:   return C_EXEC;
      T_ALUWB:  return C_ALUWB;
      T_BRANCH: return C_BR;
      default:  return 14'h0;
    endcase
  endfunction

  function automatic vec_t mkd(logic [6:0] op, logic rdy, logic [3:0] st, logic [13:0] ctrl);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.to = 1'b0; v.ill = 1'b0; v.tag = "";
    return v;
  endfunction

  function automatic void push(logic [6:0] op, logic rdy, logic [3:0] st);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl_of(st, rdy);
    v.to = to_m; v.ill = (st == T_TRAP); v.tag = pending_tag;
    pending_tag = "";
    exp_q.push_back(v);
  endfunction

  // A memory phase: w not-ready cycles then completion, or abort after MAX_WAIT.
  function automatic bit mem_phase(logic [6:0] op, logic [3:0] st, int w);
    if (w >= MAX_WAIT) begin
      for (int i = 0; i < MAX_WAIT; i++) push(op, 1'b0, st);
      to_m = 1'b1;
      return 1'b0;
    end
    for (int i = 0; i < w; i++) push(op, 1'b0, st);
    push(op, 1'b1, st);
    return 1'b1;
  endfunction

  function automatic void add_instr(logic [6:0] op, int fw, int mw, string tag);
    bit ok;
    pending_tag = tag;
    ok = mem_phase(op, T_FETCH, fw);
    push(op, 1'($urandom_range(0, 1)), T_DECODE);
    case (op)
      LD: begin
        push(op, 1'($urandom_range(0, 1)), T_MEMADR);
        if (mem_phase(op, T_MEMRD, mw)) push(op, 1'($urandom_range(0, 1)), T_MEMWB);
      end
      SD: begin
        push(op, 1'($urandom_range(0, 1)), T_MEMADR);
        ok = mem_phase(op, T_MEMWR, mw);
      end
      ADD: begin
        push(op, 1'($urandom_range(0, 1)), T_EXEC);
        push(op, 1'($urandom_range(0, 1)), T_ALUWB);
      end
      BEQ: push(op, 1'($urandom_range(0, 1)), T_BRANCH);
      default: ;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t v, string where);
    Opcode = v.op;
    mem_ready = v.rdy;
    #1;
    if (v.tag != "") $display("txn %s start at %0t", v.tag, $time);
    check({where, " state"}, int'(State), int'(v.st));
    check({where, " ctrl"}, int'(ctrl_act), int'(v.ctrl));
    check({where, " timeout"}, int'(mem_timeout), int'(v.to));
    check({where, " illegal"}, int'(illegal_instr), int'(v.ill));
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Directed table: add, beq, ld with 3 read waits (8 cycles), sd with one fetch wait.
    dir_q.push_back(mkd(ADD, 1, T_FETCH, C_FETCH_R));
    dir_q.push_back(mkd(ADD, 1, T_DECODE, C_DEC));
    dir_q.push_back(mkd(ADD, 1, T_EXEC, C_EXEC));
    dir_q.push_back(mkd(ADD, 1, T_ALUWB, C_ALUWB));
    dir_q.push_back(mkd(BEQ, 1, T_FETCH, C_FETCH_R));
    dir_q.push_back(mkd(BEQ, 1, T_DECODE, C_DEC));
    dir_q.push_back(mkd(BEQ, 1, T_BRANCH, C_BR));
    dir_q.push_back(mkd(LD, 1, T_FETCH, C_FETCH_R));
    dir_q.push_back(mkd(LD, 1, T_DECODE, C_DEC));
    dir_q.push_back(mkd(LD, 1, T_MEMADR, C_MADR));
    dir_q.push_back(mkd(LD, 0, T_MEMRD, C_MRD));
    dir_q.push_back(mkd(LD, 0, T_MEMRD, C_MRD));
    dir_q.push_back(mkd(LD, 0, T_MEMRD, C_MRD));
    dir_q.push_back(mkd(LD, 1, T_MEMRD, C_MRD));
    dir_q.push_back(mkd(LD, 1, T_MEMWB, C_MWB));
    dir_q.push_back(mkd(SD, 0, T_FETCH, C_FETCH_W));
    dir_q.push_back(mkd(SD, 1, T_FETCH, C_FETCH_R));
    dir_q.push_back(mkd(SD, 1, T_DECODE, C_DEC));
    dir_q.push_back(mkd(SD, 1, T_MEMADR, C_MADR));
    dir_q.push_back(mkd(SD, 1, T_MEMWR, C_MWR));

    // Reset: outputs 0 while held and in the S_RESET cycle after release.
    rst_n = 1'b0;
    mem_ready = 1'b1;
    Opcode = ADD;
    #12;
    check("reset state", int'(State), int'(T_RESET));
    check("reset ctrl", int'(ctrl_act), 0);
    check("reset timeout", int'(mem_timeout), 0);
    check("reset illegal", int'(illegal_instr), 0);
    step();
    rst_n = 1'b1;
    #1;
    check("post-reset state", int'(State), int'(T_RESET));
    check("post-reset ctrl", int'(ctrl_act), 0);
    step();

    for (int i = 0; i < dir_q.size(); i++) apply(dir_q[i], $sformatf("dir[%0d]", i));

    // Random instruction stream with short waits.
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 3))
        0: op = LD;
        1: op = SD;
        2: op = ADD;
        default: op = BEQ;
      endcase
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d op=%b", i, op));
    end
    // Ready arrives on the 16th read-wait cycle: completes, no timeout.
    add_instr(LD, 0, MAX_WAIT - 1, "ld ready on cycle 16");
    // Store never acknowledged: 16 MemWrite cycles then abort, timeout sticky.
    add_instr(SD, 0, MAX_WAIT + 4, "sd timeout");
    add_instr(ADD, 1, 0, "add after timeout");
    add_instr(BAD, 0, 0, "illegal opcode");
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) push(BAD, 1'($urandom_range(0, 1)), T_TRAP);
`else
    pending_tag = "add interrupted by reset";
    push(ADD, 1'b1, T_FETCH);
    push(ADD, 1'b1, T_DECODE);
`endif
    for (int i = 0; i < exp_q.size(); i++) apply(exp_q[i], $sformatf("model[%0d]", i));

    // Mid-instruction reset takes effect without a clock edge.
`ifdef ILLEGAL_TRAP_EN
    check("pre-reset state", int'(State), int'(T_TRAP));
    check("pre-reset illegal", int'(illegal_instr), 1);
`else
    check("pre-reset state", int'(State), int'(T_EXEC));
`endif
    check("pre-reset timeout", int'(mem_timeout), 1);
    rst_n = 1'b0;
    #1;
    check("async reset state", int'(State), int'(T_RESET));
    check("async reset ctrl", int'(ctrl_act), 0);
    check("async reset timeout", int'(mem_timeout), 0);
    check("async reset illegal", int'(illegal_instr), 0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("release state", int'(State), int'(T_RESET));
    step();
    check("refetch state", int'(State), int'(T_FETCH));
    check("refetch ctrl", int'(ctrl_act), int'(C_FETCH_R));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
